// File: rtl/ce_rate_gen_pkg.sv
// Shared constants, types and helpers for the clock-enable generator.
// Optional negative-phase enables are controlled by the CE_RATE_GEN_NEG_EN macro.
package ce_rate_gen_pkg;

   localparam int DIVW_DEFAULT = 7;

   typedef logic [DIVW_DEFAULT-1:0] div_t;

   // Mid-period compare point, computed wide so d at its maximum cannot overflow
   function automatic int unsigned neg_point(input int unsigned d);
      return (d + 1) >> 1;
   endfunction

endpackage

// File: rtl/ce_rate_chan.sv
// One clock-enable channel: divider counter, deferred-pulse logic and sticky miss flag.
// The ce_n comparator and register exist only when CE_RATE_GEN_NEG_EN is defined.
module ce_rate_chan
   import ce_rate_gen_pkg::*;
#(
   parameter int DIVW      = DIVW_DEFAULT,
   parameter int DIV_RESET = 111
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            en,
   input  logic [DIVW-1:0] div,
   input  logic            stall,
   input  logic            miss_clr,
   output logic            ce_p,
   output logic            ce_n,
   output logic            miss
);

   logic [DIVW-1:0] cnt;
   logic [DIVW-1:0] div_cur;
   logic            pend;
   logic            tick;
   logic            wrap;
   logic            miss_set;
   logic            ce_p_next;
   logic            pend_next;

   assign wrap     = (cnt == div_cur);
   assign tick     = en & (cnt == '0);
   assign miss_set = tick & pend;

   // The divisor is only sampled at the wrap, so a running period is never cut short
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt     <= '0;
         div_cur <= DIVW'(DIV_RESET);
      end else if (en) begin
         if (wrap) begin
            cnt     <= '0;
            div_cur <= div;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   always_comb begin
      ce_p_next = 1'b0;
      pend_next = pend;
      if (en) begin
         if (tick) begin
            if (stall) begin
               pend_next = 1'b1;
            end else begin
               ce_p_next = 1'b1;
               pend_next = 1'b0;
            end
         end else if (pend && !stall) begin
            ce_p_next = 1'b1;
            pend_next = 1'b0;
         end
      end
   end

   // A new miss in the same cycle as miss_clr must survive the clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ce_p <= 1'b0;
         pend <= 1'b0;
         miss <= 1'b0;
      end else begin
         ce_p <= ce_p_next;
         pend <= pend_next;
         miss <= miss_set | (miss & ~miss_clr);
      end
   end

`ifdef CE_RATE_GEN_NEG_EN
   logic neg_hit;

   assign neg_hit = en & (div_cur != '0) &
                    (32'(cnt) == neg_point(32'(div_cur)));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ce_n <= 1'b0;
      end else begin
         ce_n <= neg_hit;
      end
   end
`else
   assign ce_n = 1'b0;
`endif

endmodule

// File: rtl/ce_rate_gen.sv
// Multi-channel clock-enable generator: one ce_rate_chan per channel, each with its own divisor slice.
// Define CE_RATE_GEN_NEG_EN to build the mid-period ce_n outputs.
module ce_rate_gen
   import ce_rate_gen_pkg::*;
#(
   parameter int NCH       = 3,
   parameter int DIVW      = DIVW_DEFAULT,
   parameter int DIV_RESET = 111
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                en,
   input  logic [NCH*DIVW-1:0] div,
   input  logic [NCH-1:0]      stall,
   input  logic                miss_clr,
   output logic [NCH-1:0]      ce_p,
   output logic [NCH-1:0]      ce_n,
   output logic [NCH-1:0]      miss
);

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      ce_rate_chan #(
         .DIVW      (DIVW),
         .DIV_RESET (DIV_RESET)
      ) u_chan (
         .clk      (clk),
         .reset_n  (reset_n),
         .en       (en),
         .div      (div[i*DIVW +: DIVW]),
         .stall    (stall[i]),
         .miss_clr (miss_clr),
         .ce_p     (ce_p[i]),
         .ce_n     (ce_n[i]),
         .miss     (miss[i])
      );
   end

endmodule

// File: doc/ce_rate_gen.md
# ce_rate_gen

Multi-channel clock-enable generator for the core's single system clock. Each channel divides the clock by its own runtime divisor, which can change without glitches, and produces a one-cycle positive-phase enable. With the feature compiled in, it also produces a mid-period negative-phase enable. A per-channel stall input defers a due pulse instead of dropping it, and a sticky miss flag records overruns. It sits beside the reset sequencer in the top level and drives the CPU, pixel and tape enables. It replaces the hand-written dividers there.

## Interface
Parameters:
- NCH, 3, number of independent channels.
- DIVW, 7, divisor and counter width in bits.
- DIV_RESET, 111, divisor loaded into every channel at reset.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  global run; low freezes all channels.
- div  in  NCH*DIVW  per-channel divisor; channel i uses bits [i*DIVW +: DIVW]; period = div+1 cycles.
- stall  in  NCH  per-channel hold-off request.
- miss_clr  in  1  clears all miss flags.
- ce_p  out  NCH  positive-phase enable, one cycle wide, registered.
- ce_n  out  NCH  negative-phase enable, one cycle wide, registered; tied 0 unless the macro is defined.
- miss  out  NCH  sticky flag: a pulse was lost or merged while stalled.

## Operation
- Per-channel state:
  - cnt[DIVW]: reset 0.
  - div_cur[DIVW]: reset DIV_RESET.
  - pend: reset 0.
- Reset values: ce_p=0, ce_n=0, miss=0.
- Counter rule, when en=1:
  - If cnt==div_cur: cnt<=0 and div_cur<=div slice. The new divisor is sampled only here.
  - Otherwise: cnt<=cnt+1.
  - A divisor change therefore never shortens or truncates the current period.
- Tick: tick = en & (cnt==0).
- ce_p next value:
  - tick & ~stall → 1.
  - pend & ~stall → 1, and pend<=0.
  - tick & stall → ce_p=0, pend<=1.
  - Otherwise → 0.
- Miss conditions, each sets the channel's miss:
  - tick while pend=1 and stall=1. pend stays 1.
  - tick while pend=1 and stall=0. Produces one merged pulse; pend cleared.
- miss_clr clears all flags. A set in the same cycle wins over the clear.
- en=0: cnt, div_cur and pend hold. ce_p=0, ce_n=0. Pending pulses are not released while en=0.
- div=0 gives ce_p every enabled cycle. Stall still defers pulses but they merge, so miss is set.

## Timing
- ce_p rises one cycle after the enabled edge at which cnt==0.
  - First ce_p occurs after the first enabled edge following reset release.
  - ce_p then repeats every div_cur+1 cycles.
- Stall release latency: ce_p rises one cycle after the first edge sampling stall=0.
- ce_n: asserted one cycle after the enabled edge where cnt==(div_cur+1)>>1 and div_cur≥1. It is never asserted for div_cur=0. ce_n ignores stall.
- A new divisor takes effect from the period that starts after the next wrap. Latency is at most old div+1 cycles.
- Asynchronous reset mid-period immediately zeroes all outputs. The restart is phase-aligned for all channels.

## Configuration
- CE_RATE_GEN_NEG_EN:
  - Defined: ce_n is generated as described in Operation and Timing.
  - Undefined: the ce_n comparators and registers are removed; ce_n is constant 0. ce_p and miss behave identically either way.

## Structure
- Shared package ce_rate_gen_pkg holds:
  - a default DIVW constant;
  - typedef div_t (logic [DIVW-1:0]);
  - a function computing the ce_n compare point, (d+1)>>1.
- Sub-module ce_rate_chan implements one channel (cnt, div_cur, pend, miss). The top level is a generate loop over NCH instances plus slicing of the div vector.

## Test plan
- Reset release, en=1, div slice=3 → ce_p high on cycles 1, 5, 9, …; with the macro, ce_n high on cycles 3, 7, …; miss stays 0.
- Divisor change from 3 to 1 applied mid-period at cnt=1 → the current period still lasts 4 cycles, then ce_p arrives every 2 cycles.
- stall=1 across one tick, released 2 cycles later → exactly one ce_p, one cycle after release; miss=0.
- stall=1 held across two ticks with div=3 → ce_p absent; miss=1 after the second tick. On release, exactly one ce_p. miss stays 1 until miss_clr, and is still set if miss_clr coincides with another miss event.
- en=0 for 10 cycles mid-period, then en=1 → no ce_p or ce_n during the gap; the phase resumes from the frozen cnt; pend is released only after en=1.
- reset_n asserted asynchronously between edges while ce_p=1 → ce_p, ce_n and miss go to 0 immediately; div_cur becomes 111 (first period 112 cycles).
